// File: rtl/multdiv_sequencer.sv
// Sequences the multi-cycle multiply/divide unit for an instruction in DX.
// It issues a one-cycle start pulse, holds the pipeline stall until the unit
// reports ready or the timeout expires, then presents one writeback.
// Ports:
//   clock, reset    - system clock (rising edge), synchronous active-high reset
//   dx_ir           - DX instruction (opcode [31:27], rd [26:22], ALU-op [6:2])
//   md_rdy          - multdiv result ready pulse
//   md_exception    - multdiv exception, valid with md_rdy
//   md_result       - multdiv result, valid with md_rdy
//   ctrl_mult/div   - registered one-cycle start pulses to the multdiv unit
//   stall           - combinational freeze of PC/FD/DX, nop into XM
//   wb_valid        - one-cycle writeback strobe qualifying wb_rd/wb_data
//   wb_rd, wb_data  - writeback destination and value (hold outside DONE)
//   busy            - operation in flight (START or BUSY)
module multdiv_sequencer #(
  parameter int unsigned TIMEOUT      = 40,
  parameter logic [4:0]  MUL_ALUOP    = 5'b00110,
  parameter logic [4:0]  DIV_ALUOP    = 5'b00111,
  parameter logic [4:0]  RSTATUS      = 5'd30,
  parameter logic [31:0] MUL_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir,
  input  logic        md_rdy,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              is_div_q;
  logic [4:0]        rd_q;

  logic [4:0]  aluop;
  logic        is_div_op;
  logic        hit;
  logic [31:0] exc_code;

  // Instruction decode in DX
  assign aluop     = dx_ir[6:2];
  assign is_div_op = (aluop == DIV_ALUOP);
  assign hit       = (dx_ir[31:27] == 5'd0) && (dx_ir != 32'd0) &&
                     ((aluop == MUL_ALUOP) || (aluop == DIV_ALUOP));
  assign exc_code  = is_div_q ? DIV_EXC_CODE : MUL_EXC_CODE;

  // Saturating timeout counter increment
  assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Stall: combinational so a new hit freezes DX in the same cycle.
  // An unknown dx_ir falls through to the no-hit branch.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    if (hit) stall = 1'b1;
        START:   stall = 1'b1;
        BUSY:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      rd_q      <= 5'd0;
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      busy      <= 1'b0;
    end else begin
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
      wb_valid  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hit) begin
            is_div_q  <= is_div_op;
            rd_q      <= dx_ir[26:22];
            ctrl_mult <= !is_div_op;
            ctrl_div  <= is_div_op;
            busy      <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_d;
          // A ready pulse on the final timeout cycle still delivers its result
          if (md_rdy) begin
            wb_valid <= 1'b1;
            busy     <= 1'b0;
            state_q  <= DONE;
            if (md_exception) begin
              wb_rd   <= RSTATUS;
              wb_data <= exc_code;
            end else begin
              wb_rd   <= rd_q;
              wb_data <= md_result;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            wb_valid <= 1'b1;
            busy     <= 1'b0;
            state_q  <= DONE;
            wb_rd    <= RSTATUS;
            wb_data  <= exc_code;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: inputs driven 1ns after the rising
// edge, outputs sampled 3ns after it.
module tb_multdiv_sequencer;

  localparam int unsigned TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dx_ir;
  logic        md_rdy;
  logic        md_exception;
  logic [31:0] md_result;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  multdiv_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .dx_ir        (dx_ir),
    .md_rdy       (md_rdy),
    .md_exception (md_exception),
    .md_result    (md_result),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] md_instr(input logic [4:0] rd, input bit div);
    logic [4:0] op;
    op = div ? 5'b00111 : 5'b00110;
    return {5'd0, rd, 5'd1, 5'd2, 5'd0, op, 2'b00};
  endfunction

  // Runs one mul/div from its hit cycle through DONE.
  // k = BUSY cycle of md_rdy (1-based); k = 0 means md_rdy never comes.
  task automatic run_seq(input logic [4:0] rd, input bit div, input int k,
                         input logic [31:0] res, input bit exc, input bit spur,
                         input logic [4:0] exp_rd, input logic [31:0] exp_data);
    int nb;
    int stalls;
    nb = (k == 0) ? TIMEOUT : k;
    stalls = 0;
    // hit cycle
    tick();
    dx_ir = md_instr(rd, div);
    md_rdy = 1'b0;
    settle();
    check("hit_stall", stall, 1);
    check("hit_nopulse", ctrl_mult | ctrl_div, 0);
    if (stall) stalls++;
    // start cycle
    tick();
    md_rdy = spur;
    md_result = 32'hBAD0_BAD0;
    md_exception = 1'b0;
    settle();
    check("start_mult", ctrl_mult, !div);
    check("start_div", ctrl_div, div);
    check("start_busy", busy, 1);
    check("start_stall", stall, 1);
    if (stall) stalls++;
    // busy cycles
    for (int i = 1; i <= nb; i++) begin
      tick();
      md_rdy = (k != 0) && (i == k);
      md_result = res;
      md_exception = exc;
      settle();
      if (i == 1 || i == nb) begin
        check("busy_pulse", ctrl_mult | ctrl_div, 0);
        check("busy_wbv", wb_valid, 0);
        check("busy_busy", busy, 1);
      end
      if (stall) stalls++;
    end
    // done cycle
    tick();
    md_rdy = 1'b0;
    md_exception = 1'b0;
    settle();
    check("done_wbv", wb_valid, 1);
    check("done_stall", stall, 0);
    check("done_rd", wb_rd, exp_rd);
    check("done_data", wb_data, exp_data);
    check("done_busy", busy, 0);
    check("done_pulse", ctrl_mult | ctrl_div, 0);
    check("stall_cycles", stalls, nb + 2);
  endtask

  initial begin
    reset = 1'b1;
    dx_ir = md_instr(5'd3, 1'b0);
    md_rdy = 1'b0;
    md_exception = 1'b0;
    md_result = 32'd0;
    #1;
    check("rst_stall_comb", stall, 0);
    tick();
    settle();
    check("rst_stall", stall, 0);
    check("rst_pulse", ctrl_mult | ctrl_div, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd", wb_rd, 0);
    check("rst_data", wb_data, 0);
    tick();
    reset = 1'b0;
    dx_ir = 32'd0;
    settle();
    check("idle_nop_stall", stall, 0);

    // mul $3: md_rdy 4 cycles after the pulse
    run_seq(5'd3, 1'b0, 4, 32'h0000_002A, 1'b0, 1'b0, 5'd3, 32'h0000_002A);
    tick();
    dx_ir = 32'd0;
    settle();
    check("after_wbv", wb_valid, 0);
    check("after_rd_hold", wb_rd, 3);
    check("after_data_hold", wb_data, 32'h2A);

    // div $5 with exception, spurious md_rdy in START ignored
    run_seq(5'd5, 1'b1, 3, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd30, 32'd5);

    // mul timeout
    tick();
    dx_ir = 32'd0;
    settle();
    run_seq(5'd3, 1'b0, 0, 32'h0, 1'b0, 1'b0, 5'd30, 32'd4);

    // md_rdy on the final timeout cycle wins
    tick();
    dx_ir = 32'd0;
    settle();
    run_seq(5'd9, 1'b0, TIMEOUT, 32'h0000_1234, 1'b0, 1'b0, 5'd9, 32'h0000_1234);

    // rd = 0 still sequenced
    tick();
    dx_ir = 32'd0;
    settle();
    run_seq(5'd0, 1'b0, 1, 32'h0000_0007, 1'b0, 1'b0, 5'd0, 32'h0000_0007);

    // back-to-back mul $4 then div $6
    tick();
    dx_ir = 32'd0;
    settle();
    run_seq(5'd4, 1'b0, 2, 32'h0000_0011, 1'b0, 1'b0, 5'd4, 32'h0000_0011);
    run_seq(5'd6, 1'b1, 5, 32'h0000_0022, 1'b0, 1'b0, 5'd6, 32'h0000_0022);

    // reset in BUSY abandons the op
    tick();
    dx_ir = md_instr(5'd7, 1'b0);
    tick();
    tick();
    tick();
    settle();
    check("pre_rst_busy", busy, 1);
    tick();
    reset = 1'b1;
    settle();
    check("rst_busy_stall_comb", stall, 0);
    tick();
    reset = 1'b0;
    dx_ir = 32'd0;
    md_rdy = 1'b1;
    md_result = 32'h0000_0099;
    settle();
    check("rst_mid_stall", stall, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_wbv", wb_valid, 0);
    tick();
    md_rdy = 1'b0;
    settle();
    check("late_rdy_wbv", wb_valid, 0);
    check("late_rdy_pulse", ctrl_mult | ctrl_div, 0);

    // non-target instructions plus spurious md_rdy in IDLE
    tick();
    dx_ir = {5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 2'b00};
    md_rdy = 1'b1;
    settle();
    check("add_stall", stall, 0);
    tick();
    dx_ir = {5'b01000, 5'd3, 5'd1, 17'h00018};
    md_rdy = 1'b0;
    settle();
    check("lw_stall", stall, 0);
    check("add_no_pulse", ctrl_mult | ctrl_div, 0);
    check("add_no_wbv", wb_valid, 0);
    tick();
    dx_ir = 'x;
    settle();
    check("x_stall", stall, 0);
    tick();
    dx_ir = 32'd0;
    settle();
    check("x_no_pulse", ctrl_mult | ctrl_div, 0);
    check("idle_no_wbv", wb_valid, 0);
    check("idle_no_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
